copper_frame_rx: RTL and testbench

COPPER_FRAME_RX -- requirements
Module: copper_frame_rx

---
 rtl/copper_pkg.sv | 19 +
 rtl/copper_crc8.sv | 29 ++
 rtl/copper_frame_rx.sv | 159 +++++++++++++++
 tb/tb_copper_frame_rx.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/copper_pkg.sv
// rtl/copper_pkg.sv - shared copper link definitions for the frame receiver and transmitter
package copper_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_CRC,
        ST_STOP,
        ST_DONE
    } rx_state_e;

    localparam int                   CRC_WIDTH         = 8;
    localparam logic [CRC_WIDTH-1:0] CRC_POLY          = 8'h07;
    localparam logic                 START_BIT         = 1'b0;
    localparam logic                 STOP_BIT          = 1'b1;
    localparam int                   DEFAULT_BITPERIOD = 8;

endpackage

// File: rtl/copper_crc8.sv
// rtl/copper_crc8.sv - serial CRC-8 accumulator, used only when COPPER_RX_CRC_EN is defined
module copper_crc8
    import copper_pkg::*;
(
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic                 clear,
    input  logic                 bit_en,
    input  logic                 bit_in,
    output logic [CRC_WIDTH-1:0] crc
);

    logic [CRC_WIDTH-1:0] crc_q;
    logic                 fb;

    assign fb  = crc_q[CRC_WIDTH-1] ^ bit_in;
    assign crc = crc_q;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            crc_q <= '0;
        end else if (clear) begin
            crc_q <= '0;
        end else if (bit_en) begin
            crc_q <= {crc_q[CRC_WIDTH-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
        end
    end

endmodule

// File: rtl/copper_frame_rx.sv
// rtl/copper_frame_rx.sv - serial clock-count frame receiver; COPPER_RX_CRC_EN adds a trailing CRC-8 check
module copper_frame_rx
    import copper_pkg::*;
#(
    parameter int BITPERIOD = DEFAULT_BITPERIOD,
    parameter int CNTWIDTH  = 64
) (
    input  logic                clk,
    input  logic                aresetn,
    input  logic                rx_en,
    input  logic                rx_data,
    input  logic [CNTWIDTH-1:0] clkcnt,
    input  logic [CNTWIDTH-1:0] link_delay,
    output logic [CNTWIDTH-1:0] rx_clkcnt,
    output logic [CNTWIDTH-1:0] cap_clkcnt,
    output logic [CNTWIDTH-1:0] corr64,
    output logic                frame_valid,
    output logic                frame_err,
    output logic                busy,
    output logic [15:0]         frame_cnt,
    output logic [15:0]         err_cnt
);

    localparam int            TW        = $clog2(BITPERIOD);
    localparam int            BW        = $clog2(CNTWIDTH + 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(BITPERIOD / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(BITPERIOD - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(CNTWIDTH - 1);

    rx_state_e           state_q, state_d;
    logic                sync1_q, sync2_q, edge_q;
    logic [TW-1:0]       timer_q;
    logic [BW-1:0]       bitcnt_q;
    logic [CNTWIDTH-1:0] shift_q, cap_q;
    logic                bad_q;
    logic [CNTWIDTH-1:0] rx_clkcnt_q, cap_clkcnt_q, corr_q;
    logic                frame_valid_q, frame_err_q;
    logic [15:0]         frame_cnt_q, err_cnt_q;
    logic                fall, half_tick, bit_tick, crc_bad;

    assign fall      = edge_q & ~sync2_q;
    assign half_tick = (timer_q == HALF_LAST);
    assign bit_tick  = (timer_q == BIT_LAST);

`ifdef COPPER_RX_CRC_EN
    localparam logic [BW-1:0] CRC_LAST = BW'(CRC_WIDTH - 1);
    logic [CRC_WIDTH-1:0] crc_calc, crc_rx_q;

    copper_crc8 u_crc (
        .clk    (clk),
        .aresetn(aresetn),
        .clear  (state_q == ST_IDLE),
        .bit_en (state_q == ST_DATA && bit_tick),
        .bit_in (sync2_q),
        .crc    (crc_calc)
    );

    // Received CRC arrives MSB first, so shift toward the MSB.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            crc_rx_q <= '0;
        end else if (state_q == ST_CRC && bit_tick) begin
            crc_rx_q <= {crc_rx_q[CRC_WIDTH-2:0], sync2_q};
        end
    end

    assign crc_bad = (crc_rx_q != crc_calc);
`else
    assign crc_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!rx_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (fall) state_d = ST_START;
                ST_START: if (half_tick) state_d = (sync2_q == START_BIT) ? ST_DATA : ST_IDLE;
`ifdef COPPER_RX_CRC_EN
                ST_DATA:  if (bit_tick && bitcnt_q == DATA_LAST) state_d = ST_CRC;
                ST_CRC:   if (bit_tick && bitcnt_q == CRC_LAST) state_d = ST_STOP;
`else
                ST_DATA:  if (bit_tick && bitcnt_q == DATA_LAST) state_d = ST_STOP;
`endif
                ST_STOP:  if (bit_tick) state_d = ST_DONE;
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            edge_q        <= 1'b1;
            timer_q       <= '0;
            bitcnt_q      <= '0;
            shift_q       <= '0;
            cap_q         <= '0;
            bad_q         <= 1'b0;
            rx_clkcnt_q   <= '0;
            cap_clkcnt_q  <= '0;
            corr_q        <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_cnt_q   <= '0;
            err_cnt_q     <= '0;
        end else begin
            sync1_q       <= rx_data;
            sync2_q       <= sync1_q;
            edge_q        <= sync2_q;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;

            // Timer restarts on every state change and after each sampled bit.
            if (state_q == ST_IDLE || state_d != state_q || bit_tick) timer_q <= '0;
            else                                                      timer_q <= timer_q + 1'b1;

            if (state_d != state_q)
                bitcnt_q <= '0;
            else if (bit_tick && (state_q == ST_DATA || state_q == ST_CRC))
                bitcnt_q <= bitcnt_q + 1'b1;

            if (state_q == ST_IDLE && state_d == ST_START) cap_q <= clkcnt;
            if (state_q == ST_DATA && bit_tick) shift_q <= {sync2_q, shift_q[CNTWIDTH-1:1]};
            if (state_q == ST_STOP && bit_tick) bad_q <= (sync2_q != STOP_BIT) || crc_bad;

            if (state_q == ST_DONE && rx_en) begin
                if (bad_q) begin
                    frame_err_q <= 1'b1;
                    err_cnt_q   <= err_cnt_q + 1'b1;
                end else begin
                    rx_clkcnt_q   <= shift_q;
                    cap_clkcnt_q  <= cap_q;
                    corr_q        <= shift_q + link_delay - cap_q;
                    frame_valid_q <= 1'b1;
                    frame_cnt_q   <= frame_cnt_q + 1'b1;
                end
            end
        end
    end

    assign rx_clkcnt   = rx_clkcnt_q;
    assign cap_clkcnt  = cap_clkcnt_q;
    assign corr64      = corr_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign busy        = (state_q != ST_IDLE);
    assign frame_cnt   = frame_cnt_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_copper_frame_rx.sv
// tb/tb_copper_frame_rx.sv - scoreboard bench for copper_frame_rx (honours COPPER_RX_CRC_EN)
module tb_copper_frame_rx;

    localparam int BP = 8;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        rx_en = 1'b0;
    logic        rx_data = 1'b1;
    logic [63:0] clkcnt = '0;
    logic [63:0] link_delay = '0;
    logic [63:0] rx_clkcnt, cap_clkcnt, corr64;
    logic        frame_valid, frame_err, busy;
    logic [15:0] frame_cnt, err_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          good;
        logic [63:0] rx;
        logic [63:0] cap;
        logic [63:0] corr;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] exp_fc = '0;
    logic [15:0] exp_ec = '0;
    logic [63:0] last_rx = '0, last_cap = '0, last_corr = '0;

    always #5 clk = ~clk;

    copper_frame_rx #(.BITPERIOD(BP), .CNTWIDTH(64)) dut (
        .clk        (clk),
        .aresetn    (aresetn),
        .rx_en      (rx_en),
        .rx_data    (rx_data),
        .clkcnt     (clkcnt),
        .link_delay (link_delay),
        .rx_clkcnt  (rx_clkcnt),
        .cap_clkcnt (cap_clkcnt),
        .corr64     (corr64),
        .frame_valid(frame_valid),
        .frame_err  (frame_err),
        .busy       (busy),
        .frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_good(input logic [63:0] data, input logic [63:0] cap, input logic [63:0] corr);
        exp_t e;
        exp_fc++;
        last_rx = data; last_cap = cap; last_corr = corr;
        e.good = 1'b1; e.rx = data; e.cap = cap; e.corr = corr; e.cnt = exp_fc;
        sb.push_back(e);
    endtask

    task automatic expect_bad();
        exp_t e;
        exp_ec++;
        e.good = 1'b0; e.rx = last_rx; e.cap = last_cap; e.corr = last_corr; e.cnt = exp_ec;
        sb.push_back(e);
    endtask

    task automatic drive_bit(input logic b);
        rx_data = b;
        repeat (BP) @(negedge clk);
    endtask

    // Sends a frame; returns early, still driving bit nbits-1, when nbits < 64.
    task automatic send_frame(input logic [63:0] data, input logic [63:0] cap, input logic stop_v,
                              input bit flip, input int nbits, input int idle_bits);
        logic [7:0] crc;
        crc = '0;
        clkcnt = cap;
        drive_bit(1'b0);
        clkcnt = ~cap;
        for (int i = 0; i < 64; i++) begin
            if (i == nbits) return;
            crc = {crc[6:0], 1'b0} ^ ((crc[7] ^ data[i]) ? 8'h07 : 8'h00);
            drive_bit(data[i]);
        end
`ifdef COPPER_RX_CRC_EN
        if (flip) crc[0] = ~crc[0];
        for (int i = 7; i >= 0; i--) drive_bit(crc[i]);
`endif
        drive_bit(stop_v);
        repeat (idle_bits) drive_bit(1'b1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (aresetn && (frame_valid || frame_err)) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", 64'({frame_valid, frame_err}), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("pulse_valid", 64'(frame_valid), 64'(e.good));
                chk("pulse_err", 64'(frame_err), 64'(!e.good));
                chk("rx_clkcnt", rx_clkcnt, e.rx);
                chk("cap_clkcnt", cap_clkcnt, e.cap);
                chk("corr64", corr64, e.corr);
                if (e.good) chk("frame_cnt", 64'(frame_cnt), 64'(e.cnt));
                else        chk("err_cnt", 64'(err_cnt), 64'(e.cnt));
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rx_clkcnt"}, rx_clkcnt, 64'd0);
        chk({tag, "_cap_clkcnt"}, cap_clkcnt, 64'd0);
        chk({tag, "_corr64"}, corr64, 64'd0);
        chk({tag, "_pulses"}, 64'({frame_valid, frame_err}), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_frame_cnt"}, 64'(frame_cnt), 64'd0);
        chk({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
    endtask

    initial begin
        #200000000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        aresetn = 1'b1;
        rx_en = 1'b1;
        repeat (2 * BP) @(negedge clk);

        link_delay = 64'd3;
        expect_good(64'h0000_0001_0000_0000, 64'h100, 64'h0000_0000_FFFF_FF03);
        send_frame(64'h0000_0001_0000_0000, 64'h100, 1'b1, 1'b0, 64, 2);

        link_delay = 64'd0;
        expect_good(64'h0, 64'h5, 64'hFFFF_FFFF_FFFF_FFFB);
        send_frame(64'h0, 64'h5, 1'b1, 1'b0, 64, 2);

        rx_data = 1'b0;
        repeat (2) @(negedge clk);
        rx_data = 1'b1;
        repeat (3 * BP) @(negedge clk);
        chk("glitch_busy", 64'(busy), 64'd0);
        chk("glitch_frame_cnt", 64'(frame_cnt), 64'd2);
        chk("glitch_err_cnt", 64'(err_cnt), 64'd0);

        link_delay = 64'd9;
        expect_bad();
        send_frame(64'h0123_4567_89AB_CDEF, 64'h777, 1'b0, 1'b0, 64, 2);

`ifdef COPPER_RX_CRC_EN
        expect_bad();
        send_frame(64'h0123_4567_89AB_CDEF, 64'h778, 1'b1, 1'b1, 64, 2);
`endif

        link_delay = 64'd7;
        expect_good(64'hAAAA_5555_AAAA_5555, 64'h10, 64'hAAAA_5555_AAAA_554C);
        send_frame(64'hAAAA_5555_AAAA_5555, 64'h10, 1'b1, 1'b0, 64, 1);
        link_delay = 64'h100;
        expect_good(64'hFFFF_FFFF_FFFF_FFFF, 64'h20, 64'h0000_0000_0000_00DF);
        send_frame(64'hFFFF_FFFF_FFFF_FFFF, 64'h20, 1'b1, 1'b0, 64, 2);

        send_frame(64'hFFFF_0000_FFFF_0000, 64'h30, 1'b1, 1'b0, 20, 0);
        rx_en = 1'b0;
        rx_data = 1'b1;
        repeat (2) @(negedge clk);
        chk("rxen_abort_busy", 64'(busy), 64'd0);
        chk("rxen_abort_frame_cnt", 64'(frame_cnt), 64'(exp_fc));
        chk("rxen_abort_err_cnt", 64'(err_cnt), 64'(exp_ec));
        chk("rxen_abort_rx_clkcnt", rx_clkcnt, last_rx);
        rx_en = 1'b1;
        repeat (2 * BP) @(negedge clk);
        link_delay = 64'h10;
        expect_good(64'h1234_5678_9ABC_DEF0, 64'h1000, 64'h1234_5678_9ABC_CF00);
        send_frame(64'h1234_5678_9ABC_DEF0, 64'h1000, 1'b1, 1'b0, 64, 2);

        send_frame(64'h5A5A_5A5A_5A5A_5A5A, 64'h40, 1'b1, 1'b0, 20, 0);
        aresetn = 1'b0;
        rx_data = 1'b1;
        #1;
        chk_all_zero("abort_reset");
        exp_fc = '0; exp_ec = '0;
        last_rx = '0; last_cap = '0; last_corr = '0;
        repeat (3) @(negedge clk);
        aresetn = 1'b1;
        repeat (2 * BP) @(negedge clk);
        link_delay = 64'd3;
        expect_good(64'h0000_0001_0000_0000, 64'h100, 64'h0000_0000_FFFF_FF03);
        send_frame(64'h0000_0001_0000_0000, 64'h100, 1'b1, 1'b0, 64, 2);

        repeat (4 * BP) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        chk("final_frame_cnt", 64'(frame_cnt), 64'd1);
        chk("final_err_cnt", 64'(err_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
